edge_function_array: RTL and testbench
======================================

# edge_function_array

Parametrised successor to the single-line edge-function evaluator: tests each streamed pixel against `NUM_LINES` line segments in parallel, using one 3-stage pipeline per line. Line endpoints are held in an internal register file that the host writes one line at a time; a frame-synchronous swap commits the written set. The block sits between the pixel timing generator and the colour output stage. It returns a per-line hit mask and an OR-reduced pixel flag, with a fixed latency and valid tagging.

## Interface
- `LINE_BITS`, 10: coordinate width (unsigned).
- `NUM_LINES`, 4: number of line slots (≥1).
- `THRESH_BITS`, 12: threshold width (≤ 2·LINE_BITS).
- `IDX_BITS`, $clog2(NUM_LINES) (min 1): slot index width.

Ports:
- `clk_i`  in  1  clock; everything is on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `line_we_i`  in  1  write strobe for one line slot.
- `line_idx_i`  in  IDX_BITS  slot to write; values ≥ NUM_LINES are ignored.
- `line_data_i`  in  4·LINE_BITS  packed as {x0, y0, x1, y1}, with x0 in the MSBs.
- `line_en_i`  in  1  enable bit stored with the slot.
- `swap_i`  in  1  pulse that commits the shadow set to the active set.
- `thresh_i`  in  THRESH_BITS  global distance threshold, sampled with the pixel.
- `pixel_valid_i`  in  1  pixel qualifier.
- `pixel_x_i`, `pixel_y_i`  in  LINE_BITS each  pixel position.
- `pixel_valid_o`  out  1  `pixel_valid_i` delayed by 3 cycles.
- `hit_mask_o`  out  NUM_LINES  per-line hit.
- `pixel_set_o`  out  1  OR of `hit_mask_o`.

## Operation
- **Register file:** each slot has an active copy and a shadow copy. A slot holds {x0, y0, x1, y1, en}.
- **Write:** when `line_we_i` is high, `line_idx_i` selects the shadow slot written with `line_data_i` and `line_en_i`.
- **Swap:** when `swap_i` is high, every active slot takes the shadow value from before this edge. A write in the same cycle lands in the shadow copy only.
- **Stage 1, per active enabled slot:**
  - Order the endpoints so that y0 ≤ y1; swap both points when y0 > y1.
  - right = (x1 ≥ x0).
  - Register four LINE_BITS terms:
    - right side: t0 = px−x0, t1 = y1−py, t2 = x1−px, t3 = py−y0;
    - left side: t0 = x0−px, t2 = px−x1, with t1 and t3 unchanged.
  - Register `vis` = py within [y0, y1] and px within the x span, both bounds inclusive.
  - Register `thresh_i` and the valid bit.
- **Stage 2:** m1 = t0·t1 and m2 = t2·t3, each 2·LINE_BITS wide, unsigned and registered. `vis`, threshold and valid are pipelined alongside.
- **Stage 3:** register hit[i] = vis ∧ en ∧ (|m1−m2| < thresh). The compare zero-extends thresh to 2·LINE_BITS.
- Terms may wrap when `vis` = 0; the hit is masked in that case, so the wrapped values have no effect.
- Hits are evaluated independently of `pixel_valid_i`. `hit_mask_o` and `pixel_set_o` are forced to 0 whenever `pixel_valid_o` = 0.
- **Degenerate line** (both endpoints equal): the hit is true only at that point, and only if thresh > 0. thresh = 0 never hits.

## Timing
- **Reset:**
  - all active and shadow slots are cleared to 0 with en = 0;
  - all pipeline valid and vis bits are cleared;
  - `pixel_valid_o`, `hit_mask_o` and `pixel_set_o` are all 0.
- **Reset mid-stream:** in-flight pixels are discarded and no output pulse follows reset release.
- **Latency:** a pixel presented at edge N appears on the outputs after edge N+3. Throughput is one pixel per cycle with no stall.
- **Swap boundary:**
  - a pixel presented in the same cycle as `swap_i` uses the old active set;
  - the next pixel uses the new set;
  - pixels already in flight are unaffected.
- **Threshold:** a `thresh_i` change takes effect for the pixel sampled in the same cycle.

## Configuration
- `EDGE_SHADOW_EN` defined: the double-buffered behaviour described above.
- `EDGE_SHADOW_EN` undefined:
  - no shadow copy is built;
  - writes update the active slot directly and affect the pixel presented in the next cycle;
  - `swap_i` is ignored.

## Test plan
All scenarios use LINE_BITS = 8 and NUM_LINES = 4.
- Reset, then stream pixels with no lines enabled -> `pixel_set_o` = 0 and `hit_mask_o` = 0. `pixel_valid_o` follows `pixel_valid_i` 3 cycles later.
- Slot 0 = (10,10)-(20,20), thresh 1, swap; then pixel (15,15) -> `hit_mask_o` = 0001, 3 cycles after presentation.
  - Pixel (16,15): |30−20| = 10 -> no hit with thresh 1, hit with thresh 11.
- Slot 1 = (20,20)-(10,10) (reversed endpoints) -> same hits as slot 0. Slot 2 = (20,10)-(10,20) (left side): pixel (15,15) -> hit; pixel (21,15) -> no hit (outside the box).
- Write slot 3 without swap -> no effect until `swap_i`. Write and swap in the same cycle -> the new value is visible only after a second swap (shadow build only).
  - Pixel presented in the swap cycle -> evaluated with the old set.
- Degenerate slot (5,5)-(5,5): pixel (5,5) with thresh 0 -> no hit; with thresh 1 -> hit. Pixel (6,5) -> no hit.
- Assert `rst_ni` low with 3 hit pixels in flight -> outputs 0 immediately and no hits after release. `line_idx_i` ≥ NUM_LINES (NUM_LINES = 3) -> write ignored.

Source files
------------

// File: rtl/edge_function_array.sv
// -----------------------------------------------------------------------------
// edge_function_array
//
// Tests every streamed pixel against NUM_LINES line segments in parallel.
// Each slot runs its own 3-stage pipeline:
//   stage 1: order endpoints by y, form four edge-distance terms and the
//            bounding-box visibility flag
//   stage 2: two products m1 = t0*t1 and m2 = t2*t3
//   stage 3: hit = vis & en & (|m1 - m2| < thresh)
// Threshold and valid travel in a shared pipeline next to the slots.
//
// Build option:
//   EDGE_SHADOW_EN defined   : each slot has a shadow copy written by the host,
//                              and swap_i commits all shadows to the active set.
//   EDGE_SHADOW_EN undefined : writes go straight to the active set and
//                              swap_i is ignored.
//
// Ports:
//   clk_i, rst_ni     clock (rising edge), asynchronous active-low reset
//   line_we_i         write strobe for one slot
//   line_idx_i        slot index; indices >= NUM_LINES are ignored
//   line_data_i       {x0, y0, x1, y1}, x0 in the MSBs
//   line_en_i         enable stored with the slot
//   swap_i            commit shadow set to active set
//   thresh_i          distance threshold, sampled with the pixel
//   pixel_valid_i     pixel qualifier
//   pixel_x_i/y_i     pixel position
//   pixel_valid_o     pixel_valid_i delayed by 3 cycles
//   hit_mask_o        per-line hit, zero when pixel_valid_o is low
//   pixel_set_o       OR of hit_mask_o
// -----------------------------------------------------------------------------
module edge_function_array #(
  parameter int LINE_BITS   = 10,
  parameter int NUM_LINES   = 4,
  parameter int THRESH_BITS = 12,
  parameter int IDX_BITS    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   line_we_i,
  input  logic [IDX_BITS-1:0]    line_idx_i,
  input  logic [4*LINE_BITS-1:0] line_data_i,
  input  logic                   line_en_i,
  input  logic                   swap_i,
  input  logic [THRESH_BITS-1:0] thresh_i,
  input  logic                   pixel_valid_i,
  input  logic [LINE_BITS-1:0]   pixel_x_i,
  input  logic [LINE_BITS-1:0]   pixel_y_i,
  output logic                   pixel_valid_o,
  output logic [NUM_LINES-1:0]   hit_mask_o,
  output logic                   pixel_set_o
);

  localparam int SLOT_W = 4 * LINE_BITS + 1;
  localparam int PROD_W = 2 * LINE_BITS;

  logic [SLOT_W-1:0]    wr_slot;
  logic [NUM_LINES-1:0] hit_vec;

  assign wr_slot = {line_data_i, line_en_i};

`ifndef EDGE_SHADOW_EN
  logic unused_swap;
  assign unused_swap = swap_i;
`endif

  // Shared valid / threshold pipeline.
  logic                   s1_valid_q, s1_valid_d;
  logic                   s2_valid_q, s2_valid_d;
  logic                   s3_valid_q, s3_valid_d;
  logic [THRESH_BITS-1:0] s1_thresh_q, s1_thresh_d;
  logic [THRESH_BITS-1:0] s2_thresh_q, s2_thresh_d;

  always_comb begin
    s1_valid_d  = pixel_valid_i;
    s2_valid_d  = s1_valid_q;
    s3_valid_d  = s2_valid_q;
    s1_thresh_d = thresh_i;
    s2_thresh_d = s1_thresh_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s1_thresh_q <= '0;
      s2_thresh_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      s1_thresh_q <= s1_thresh_d;
      s2_thresh_q <= s2_thresh_d;
    end
  end

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_slot
    logic [SLOT_W-1:0]    act_q, act_d;
    logic                 wr_sel;
    logic [LINE_BITS-1:0] x0, y0, x1, y1;
    logic [LINE_BITS-1:0] xa, ya, xb, yb;
    logic                 en, right, in_x, in_y;
    logic [LINE_BITS-1:0] t0_q, t0_d, t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
    logic                 vis1_q, vis1_d, vis2_q, vis2_d;
    logic [PROD_W-1:0]    m1_q, m1_d, m2_q, m2_d, diff;
    logic                 hit_q, hit_d;

    // Indices outside 0..NUM_LINES-1 match no slot, so they are dropped here.
    assign wr_sel = line_we_i && (line_idx_i == IDX_BITS'(gi));

`ifdef EDGE_SHADOW_EN
    logic [SLOT_W-1:0] shd_q, shd_d;

    // Swap copies the pre-edge shadow, so a same-cycle write stays in shadow.
    always_comb begin
      shd_d = wr_sel ? wr_slot : shd_q;
      act_d = swap_i ? shd_q : act_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) shd_q <= '0;
      else         shd_q <= shd_d;
    end
`else
    always_comb begin
      act_d = wr_sel ? wr_slot : act_q;
    end
`endif

    assign x0 = act_q[4*LINE_BITS -: LINE_BITS];
    assign y0 = act_q[3*LINE_BITS -: LINE_BITS];
    assign x1 = act_q[2*LINE_BITS -: LINE_BITS];
    assign y1 = act_q[LINE_BITS   -: LINE_BITS];
    assign en = act_q[0];

    // Stage 1: (xa,ya) is the endpoint with the smaller y.
    always_comb begin
      if (y0 > y1) begin
        xa = x1; ya = y1; xb = x0; yb = y0;
      end else begin
        xa = x0; ya = y0; xb = x1; yb = y1;
      end
      right = (xb >= xa);
      t0_d  = right ? (pixel_x_i - xa) : (xa - pixel_x_i);
      t1_d  = yb - pixel_y_i;
      t2_d  = right ? (xb - pixel_x_i) : (pixel_x_i - xb);
      t3_d  = pixel_y_i - ya;
      in_y  = (pixel_y_i >= ya) && (pixel_y_i <= yb);
      in_x  = right ? ((pixel_x_i >= xa) && (pixel_x_i <= xb))
                    : ((pixel_x_i >= xb) && (pixel_x_i <= xa));
      // The enable is folded in here so the pixel keeps the enable of the
      // set it was sampled against, even if a swap follows.
      vis1_d = in_y && in_x && en;
    end

    // Stage 2 / stage 3. Wrapped terms only occur when vis is 0.
    always_comb begin
      m1_d   = PROD_W'(t0_q) * PROD_W'(t1_q);
      m2_d   = PROD_W'(t2_q) * PROD_W'(t3_q);
      vis2_d = vis1_q;
      diff   = (m1_q >= m2_q) ? (m1_q - m2_q) : (m2_q - m1_q);
      hit_d  = vis2_q && (diff < PROD_W'(s2_thresh_q));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        act_q  <= '0;
        t0_q   <= '0;
        t1_q   <= '0;
        t2_q   <= '0;
        t3_q   <= '0;
        vis1_q <= 1'b0;
        vis2_q <= 1'b0;
        m1_q   <= '0;
        m2_q   <= '0;
        hit_q  <= 1'b0;
      end else begin
        act_q  <= act_d;
        t0_q   <= t0_d;
        t1_q   <= t1_d;
        t2_q   <= t2_d;
        t3_q   <= t3_d;
        vis1_q <= vis1_d;
        vis2_q <= vis2_d;
        m1_q   <= m1_d;
        m2_q   <= m2_d;
        hit_q  <= hit_d;
      end
    end

    assign hit_vec[gi] = hit_q;
  end

  assign pixel_valid_o = s3_valid_q;
  assign hit_mask_o    = s3_valid_q ? hit_vec : '0;
  assign pixel_set_o   = |hit_mask_o;

endmodule

// File: tb/tb_edge_function_array.sv
// -----------------------------------------------------------------------------
// Bench for edge_function_array (LINE_BITS = 8). A 4-slot instance and a 3-slot
// instance share all inputs; the 3-slot one must ignore writes to index 3.
// Expected hits come from a geometric model: the pixel lies inside the segment's
// bounding box and the magnitude of the cross product of (B-A) and (P-A) is
// below the threshold.
// -----------------------------------------------------------------------------
module tb_edge_function_array;

  localparam int LB = 8;
  localparam int TB = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [1:0]    idx;
  logic [4*LB-1:0] data;
  logic          en_b;
  logic          swap;
  logic [TB-1:0] thresh;
  logic          pv;
  logic [LB-1:0] px, py;
  logic          valid_o, set_o, valid3_o, set3_o;
  logic [3:0]    mask_o;
  logic [2:0]    mask3_o;

  always #5 clk = ~clk;

  edge_function_array #(.LINE_BITS(LB), .NUM_LINES(4), .THRESH_BITS(TB)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .line_we_i(we), .line_idx_i(idx),
    .line_data_i(data), .line_en_i(en_b), .swap_i(swap), .thresh_i(thresh),
    .pixel_valid_i(pv), .pixel_x_i(px), .pixel_y_i(py),
    .pixel_valid_o(valid_o), .hit_mask_o(mask_o), .pixel_set_o(set_o)
  );

  edge_function_array #(.LINE_BITS(LB), .NUM_LINES(3), .THRESH_BITS(TB)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .line_we_i(we), .line_idx_i(idx),
    .line_data_i(data), .line_en_i(en_b), .swap_i(swap), .thresh_i(thresh),
    .pixel_valid_i(pv), .pixel_x_i(px), .pixel_y_i(py),
    .pixel_valid_o(valid3_o), .hit_mask_o(mask3_o), .pixel_set_o(set3_o)
  );

  typedef struct {
    bit       v;
    bit [3:0] m;
  } exp_t;

  exp_t        exp_q[$];
  logic [32:0] act_m[4];
  logic [32:0] shd_m[4];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          verbose = 1'b1;
  string       phase   = "reset";

  function automatic bit ref_hit(logic [32:0] s, int qx, int qy, int th);
    int x0, y0, x1, y1, cr;
    x0 = int'(s[32:25]);
    y0 = int'(s[24:17]);
    x1 = int'(s[16:9]);
    y1 = int'(s[8:1]);
    if (!s[0]) return 1'b0;
    if (qx < ((x0 < x1) ? x0 : x1) || qx > ((x0 > x1) ? x0 : x1)) return 1'b0;
    if (qy < ((y0 < y1) ? y0 : y1) || qy > ((y0 > y1) ? y0 : y1)) return 1'b0;
    cr = (x1 - x0) * (qy - y0) - (y1 - y0) * (qx - x0);
    if (cr < 0) cr = -cr;
    return cr < th;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s [%s]: observed %0h expected %0h", tag, phase, got, want);
    end
  endtask

  task automatic prefill();
    exp_t z;
    z.v = 1'b0;
    z.m = 4'b0;
    exp_q.delete();
    repeat (2) exp_q.push_back(z);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      act_m[i] = '0;
      shd_m[i] = '0;
    end
  endtask

  // One clock: record the expectation for the pixel on the inputs, let the
  // edge happen, update the model register file, then compare the output of
  // the pixel presented three edges earlier.
  task automatic tick();
    exp_t e, o;
    e.v = pv;
    e.m = '0;
    for (int i = 0; i < 4; i++)
      e.m[i] = pv & ref_hit(act_m[i], int'(px), int'(py), int'(thresh));
    exp_q.push_back(e);
    @(posedge clk);
`ifdef EDGE_SHADOW_EN
    if (swap) for (int i = 0; i < 4; i++) act_m[i] = shd_m[i];
    if (we) shd_m[idx] = {data, en_b};
`else
    if (we) act_m[idx] = {data, en_b};
`endif
    @(negedge clk);
    o = exp_q.pop_front();
    if (verbose)
      $display("[TB] %s: valid=%0b mask=%b set=%0b (want %0b/%b)",
               phase, valid_o, mask_o, set_o, o.v, o.m);
    check("valid",  32'(valid_o),  32'(o.v));
    check("mask",   32'(mask_o),   32'(o.m));
    check("set",    32'(set_o),    32'(|o.m));
    check("valid3", 32'(valid3_o), 32'(o.v));
    check("mask3",  32'(mask3_o),  32'(o.m[2:0]));
  endtask

  task automatic write_line(int i, int x0, int y0, int x1, int y1, bit e);
    we   = 1'b1;
    idx  = 2'(i);
    data = {8'(x0), 8'(y0), 8'(x1), 8'(y1)};
    en_b = e;
    tick();
    we   = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic pix(int x, int y, int th);
    pv     = 1'b1;
    px     = 8'(x);
    py     = 8'(y);
    thresh = 12'(th);
    tick();
    pv     = 1'b0;
  endtask

  task automatic flush();
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; idx = '0; data = '0; en_b = 1'b0; swap = 1'b0;
    thresh = '0; pv = 1'b0; px = '0; py = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_mask",  32'(mask_o),  32'd0);
    check("rst_set",   32'(set_o),   32'd0);
    rst_n = 1'b1;
    prefill();

    phase = "no_lines";
    for (int i = 0; i < 6; i++) begin
      pv = (i % 3) != 1;
      px = 8'($urandom_range(0, 255));
      py = 8'($urandom_range(0, 255));
      thresh = 12'($urandom_range(0, 4095));
      tick();
    end
    pv = 1'b0;
    flush();

    phase = "slot0";
    write_line(0, 10, 10, 20, 20, 1'b1);
    do_swap();
    pix(15, 15, 1);
    pix(16, 15, 1);
    pix(16, 15, 11);
    flush();

    phase = "slot1_reversed";
    write_line(1, 20, 20, 10, 10, 1'b1);
    do_swap();
    pix(15, 15, 1);
    pix(16, 15, 1);
    pix(16, 15, 11);
    flush();

    phase = "slot2_left";
    write_line(2, 20, 10, 10, 20, 1'b1);
    do_swap();
    pix(15, 15, 1);
    pix(21, 15, 50);
    flush();

    phase = "write_no_swap";
    write_line(3, 0, 0, 30, 30, 1'b1);
    pix(25, 25, 1);
    phase = "write_and_swap";
    we = 1'b1; idx = 2'd3; data = {8'd0, 8'd30, 8'd30, 8'd0}; en_b = 1'b1;
    swap = 1'b1; pv = 1'b1; px = 8'd25; py = 8'd25; thresh = 12'd1;
    tick();
    we = 1'b0; swap = 1'b0;
    pix(25, 25, 1);
    pix(25, 5, 1);
    do_swap();
    pix(25, 5, 1);
    flush();

    phase = "degenerate";
    write_line(3, 5, 5, 5, 5, 1'b1);
    do_swap();
    pix(5, 5, 0);
    pix(5, 5, 1);
    pix(6, 5, 1);
    flush();

    phase = "reset_midstream";
    pv = 1'b1; px = 8'd15; py = 8'd15; thresh = 12'd1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(valid_o), 32'd0);
    check("rst_mid_mask",  32'(mask_o),  32'd0);
    check("rst_mid_set",   32'(set_o),   32'd0);
    pv = 1'b0;
    model_clear();
    prefill();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flush();
    pix(15, 15, 1);
    flush();

    phase = "idx3_ignored";
    write_line(3, 0, 0, 40, 40, 1'b1);
    do_swap();
    pix(20, 20, 1);
    flush();

    phase = "random";
    verbose = 1'b0;
    for (int i = 0; i < 600; i++) begin
      we     = ($urandom_range(0, 3) == 0);
      idx    = 2'($urandom_range(0, 3));
      data   = {8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)),
                8'($urandom_range(0, 40)), 8'($urandom_range(0, 40))};
      en_b   = ($urandom_range(0, 3) != 0);
      swap   = ($urandom_range(0, 5) == 0);
      pv     = ($urandom_range(0, 7) != 0);
      px     = 8'($urandom_range(0, 45));
      py     = 8'($urandom_range(0, 45));
      thresh = 12'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 4095)
                                               : $urandom_range(0, 120));
      tick();
    end
    we = 1'b0; swap = 1'b0; pv = 1'b0;
    flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
